// File: rtl/dac_update_arbiter_pkg.sv
// Shared types and helpers for the DAC update arbiter: FSM state encoding,
// default sizing and round-robin pointer arithmetic.
package dac_update_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LAUNCH     = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } arb_state_t;

  localparam int DAC_DATA_WIDTH      = 16;
  localparam int DAC_TIMEOUT_DEFAULT = 4096;
  localparam int DAC_N_REQ_DEFAULT   = 4;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Pointer to the requester after the winner, wrapping to 0.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dac_update_arbiter_if.sv
// Requester and SPI-controller signals of the DAC update arbiter.
// slave: the arbiter itself; master: the requester / SPI controller side.
interface dac_update_arbiter_if
  import dac_update_arbiter_pkg::*;
#(
  parameter int N_REQ      = DAC_N_REQ_DEFAULT,
  parameter int DATA_WIDTH = DAC_DATA_WIDTH
) ();

  localparam int ID_W = id_width(N_REQ);

  logic [N_REQ-1:0]            req_i;
  logic [N_REQ*DATA_WIDTH-1:0] data_i;
  logic [N_REQ-1:0]            ack_o;
  logic [DATA_WIDTH-1:0]       spi_data_o;
  logic                        spi_renew_o;
  logic                        spi_busy_i;
  logic                        spi_en_o;
  logic [ID_W-1:0]             active_id_o;
  logic                        busy_o;
  logic                        err_timeout_o;
  logic                        err_clr_i;

  modport slave (
    input  req_i, data_i, spi_busy_i, err_clr_i,
    output ack_o, spi_data_o, spi_renew_o, spi_en_o, active_id_o, busy_o, err_timeout_o
  );

  modport master (
    output req_i, data_i, spi_busy_i, err_clr_i,
    input  ack_o, spi_data_o, spi_renew_o, spi_en_o, active_id_o, busy_o, err_timeout_o
  );

endinterface

// File: rtl/dac_update_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Returns one-hot grant, its index and a valid flag.
module rr_arbiter
  import dac_update_arbiter_pkg::*;
#(
  parameter int N  = DAC_N_REQ_DEFAULT,
  localparam int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;
  logic          hi_vld;
  logic          lo_vld;

  // Two scans: lowest request at/above ptr wins, else lowest overall (wrap).
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        lo_idx = IW'(k);
        lo_vld = 1'b1;
        if (IW'(k) >= ptr) begin
          hi_idx = IW'(k);
          hi_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    valid = lo_vld;
    idx   = hi_vld ? hi_idx : lo_idx;
    if (lo_vld) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/dac_update_arbiter.sv
// Shares one SPI DAC controller between N_REQ requesters: round-robin grant,
// code capture, renew strobe, busy tracking with timeout, and completion ack.
module dac_update_arbiter
  import dac_update_arbiter_pkg::*;
#(
  parameter int N_REQ       = DAC_N_REQ_DEFAULT,
  parameter int DATA_WIDTH  = DAC_DATA_WIDTH,
  parameter int TIMEOUT_CYC = DAC_TIMEOUT_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  dac_update_arbiter_if.slave bus
);

  localparam int IW = id_width(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  arb_state_t            state;
  logic [IW-1:0]         rr_ptr;
  logic [CW-1:0]         cnt;

  logic [N_REQ-1:0]      elig;
  logic [N_REQ-1:0]      grant;
  logic [IW-1:0]         grant_idx;
  logic                  grant_vld;
  logic [DATA_WIDTH-1:0] sel_data;

  logic [DATA_WIDTH-1:0] spi_data_q;
  logic [IW-1:0]         active_id_q;
  logic                  renew_q;
  logic                  en_q;
  logic                  busy_q;
  logic [N_REQ-1:0]      ack_q;
  logic                  err_q;

  function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + CW'(1);
  endfunction

  function automatic logic [N_REQ-1:0] id_onehot(input logic [IW-1:0] id);
    logic [N_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // A requester being acked this cycle cannot win again until it re-requests.
  assign elig = bus.req_i & ~ack_q;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (elig),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .valid (grant_vld)
  );

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) sel_data = sel_data | bus.data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      cnt         <= '0;
      spi_data_q  <= '0;
      active_id_q <= '0;
      renew_q     <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      ack_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      renew_q <= 1'b0;
      ack_q   <= '0;
      // A timeout later in this block overrides the clear.
      if (bus.err_clr_i) err_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            spi_data_q  <= sel_data;
            active_id_q <= grant_idx;
            rr_ptr      <= IW'(rr_next(int'(grant_idx), N_REQ));
            en_q        <= 1'b1;
            busy_q      <= 1'b1;
            state       <= ST_LAUNCH;
          end
        end

        ST_LAUNCH: begin
          cnt     <= '0;
          renew_q <= 1'b1;
          state   <= bus.spi_busy_i ? ST_WAIT_DONE : ST_WAIT_START;
        end

        ST_WAIT_START: begin
          if (bus.spi_busy_i) begin
            cnt   <= '0;
            state <= ST_WAIT_DONE;
          end else if (cnt >= CNT_LAST) begin
            err_q  <= 1'b1;
            ack_q  <= id_onehot(active_id_q);
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt_sat_inc(cnt);
          end
        end

        ST_WAIT_DONE: begin
          if (!bus.spi_busy_i) begin
            ack_q  <= id_onehot(active_id_q);
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else if (cnt >= CNT_LAST) begin
            err_q  <= 1'b1;
            ack_q  <= id_onehot(active_id_q);
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt_sat_inc(cnt);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack_o         = ack_q;
  assign bus.spi_data_o    = spi_data_q;
  assign bus.spi_renew_o   = renew_q;
  assign bus.spi_en_o      = en_q;
  assign bus.active_id_o   = active_id_q;
  assign bus.busy_o        = busy_q;
  assign bus.err_timeout_o = err_q;

endmodule

// File: tb/tb_dac_update_arbiter.sv
// Directed bench for dac_update_arbiter: scoreboard of expected grants,
// behavioural SPI controller, timeout and reset scenarios.
module tb_dac_update_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TO = 64;

  typedef struct {
    int          id;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;

  exp_t exp_q[$];
  int   cur_id      = 0;
  int   ack_total   = 0;
  int   renew_total = 0;
  int   ack_cnt[N];

  logic model_on   = 1'b1;
  logic force_busy = 1'b0;
  int   busy_len   = 20;
  int   busy_cnt   = 0;

  dac_update_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

  dac_update_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // SPI controller model: busy for busy_len cycles starting the cycle after renew.
  always @(posedge clk) begin
    if (model_on && bus.spi_renew_o) busy_cnt <= busy_len;
    else if (busy_cnt != 0)          busy_cnt <= busy_cnt - 1;
  end
  assign bus.spi_busy_i = force_busy | (busy_cnt != 0);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int id);
    return 4'b0001 << id;
  endfunction

  // Scoreboard: each renew pops one expected grant; each ack must match it.
  always @(negedge clk) begin
    if (bus.spi_renew_o === 1'b1) begin
      renew_total++;
      chk("renew_has_expectation", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("grant_id", 64'(bus.active_id_o), 64'(e.id));
        chk("grant_data", 64'(bus.spi_data_o), 64'(e.data));
        cur_id = e.id;
      end
    end
    if (bus.ack_o !== '0) begin
      ack_total++;
      for (int k = 0; k < N; k++) if (bus.ack_o[k]) ack_cnt[k]++;
      chk("ack_vector", 64'(bus.ack_o), 64'(oh(cur_id)));
    end
  end

  task automatic wait_ack(input int budget, output logic [N-1:0] a);
    a = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.ack_o !== '0) begin
        a = bus.ack_o;
        return;
      end
    end
  endtask

  task automatic wait_renew(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.spi_renew_o === 1'b1) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  task automatic push(input int id, input logic [15:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] a;
    logic         seen;
    int           n;

    for (int k = 0; k < N; k++) ack_cnt[k] = 0;
    rst         = 1'b1;
    bus.req_i   = '0;
    bus.data_i  = '0;
    bus.err_clr_i = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({bus.ack_o, bus.spi_data_o, bus.spi_renew_o, bus.spi_en_o,
                              bus.active_id_o, bus.busy_o, bus.err_timeout_o}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single request, normal transfer, renew two cycles after the request.
    bus.data_i[1*DW +: DW] = 16'h1234;
    bus.req_i = 4'b0010;
    push(1, 16'h1234);
    @(negedge clk);
    chk("t1_renew_not_yet", 64'(bus.spi_renew_o), 64'd0);
    chk("t1_en_in_launch", 64'(bus.spi_en_o), 64'd1);
    @(negedge clk);
    chk("t1_renew_pulse", 64'(bus.spi_renew_o), 64'd1);
    @(negedge clk);
    chk("t1_renew_one_cycle", 64'(bus.spi_renew_o), 64'd0);
    wait_ack(60, a);
    bus.req_i = '0;
    chk("t1_ack", 64'(a), 64'(4'b0010));
    chk("t1_err", 64'(bus.err_timeout_o), 64'd0);
    chk("t1_data_held", 64'(bus.spi_data_o), 64'h1234);
    @(negedge clk);
    chk("t1_idle_busy", 64'(bus.busy_o), 64'd0);

    // Requester 2 drops req and changes its code right after the grant.
    bus.data_i[2*DW +: DW] = 16'h5A5A;
    bus.req_i = 4'b0100;
    push(2, 16'h5A5A);
    @(negedge clk);
    bus.req_i = '0;
    bus.data_i[2*DW +: DW] = 16'hFFFF;
    wait_ack(60, a);
    chk("t6_ack_after_drop", 64'(a), 64'(4'b0100));
    chk("t6_data_latched", 64'(bus.spi_data_o), 64'h5A5A);

    // Reset in the middle of WAIT_DONE.
    bus.data_i[0*DW +: DW] = 16'h0BAD;
    bus.req_i = 4'b0001;
    push(0, 16'h0BAD);
    wait_renew(10, seen);
    chk("t5_renew_seen", 64'(seen), 64'd1);
    repeat (5) @(negedge clk);
    chk("t5_in_transfer", 64'(bus.busy_o), 64'd1);
    n = ack_total;
    #2 rst = 1'b1;
    #1;
    chk("t5_async_reset_outputs", 64'({bus.ack_o, bus.spi_data_o, bus.spi_renew_o, bus.spi_en_o,
                                       bus.active_id_o, bus.busy_o, bus.err_timeout_o}), 64'd0);
    bus.req_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("t5_no_ack", 64'(ack_total), 64'(n));

    // All requesters held high: order 0,1,2,3,0 from a freshly reset pointer.
    for (int k = 0; k < N; k++) bus.data_i[k*DW +: DW] = 16'hA000 + 16'(k);
    push(0, 16'hA000); push(1, 16'hA001); push(2, 16'hA002); push(3, 16'hA003); push(0, 16'hA000);
    bus.req_i = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_ack(60, a);
      if (t == 4) bus.req_i = '0;
      chk("t2_order", 64'(a), 64'(oh(t % N)));
    end

    // SPI never starts: WAIT_START timeout, TO cycles after renew.
    model_on = 1'b0;
    bus.data_i[1*DW +: DW] = 16'h0042;
    bus.req_i = 4'b0010;
    push(1, 16'h0042);
    wait_renew(10, seen);
    chk("t3_renew_seen", 64'(seen), 64'd1);
    n = 0;
    a = '0;
    while (n < TO + 10 && a == '0) begin
      @(negedge clk);
      n++;
      a = bus.ack_o;
    end
    bus.req_i = '0;
    chk("t3_timeout_cycles", 64'(n), 64'(TO));
    chk("t3_ack", 64'(a), 64'(4'b0010));
    chk("t3_err_set", 64'(bus.err_timeout_o), 64'd1);
    chk("t3_back_idle", 64'(bus.busy_o), 64'd0);
    model_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("t3_err_sticky", 64'(bus.err_timeout_o), 64'd1);
    bus.err_clr_i = 1'b1;
    @(negedge clk);
    bus.err_clr_i = 1'b0;
    chk("t3_err_cleared", 64'(bus.err_timeout_o), 64'd0);

    // Busy stuck high: WAIT_DONE timeout, with a clear in the timeout cycle.
    force_busy = 1'b1;
    bus.data_i[2*DW +: DW] = 16'h7777;
    bus.req_i = 4'b0100;
    push(2, 16'h7777);
    wait_renew(10, seen);
    chk("t4_renew_seen", 64'(seen), 64'd1);
    repeat (TO - 1) @(negedge clk);
    bus.err_clr_i = 1'b1;
    @(negedge clk);
    bus.err_clr_i = 1'b0;
    bus.req_i = '0;
    chk("t4_ack", 64'(bus.ack_o), 64'(4'b0100));
    chk("t4_set_beats_clear", 64'(bus.err_timeout_o), 64'd1);
    force_busy = 1'b0;
    @(negedge clk);
    bus.data_i[3*DW +: DW] = 16'hC3C3;
    bus.req_i = 4'b1000;
    push(3, 16'hC3C3);
    wait_ack(60, a);
    bus.req_i = '0;
    chk("t4_next_served", 64'(a), 64'(4'b1000));
    chk("t4_err_still_set", 64'(bus.err_timeout_o), 64'd1);
    bus.err_clr_i = 1'b1;
    @(negedge clk);
    bus.err_clr_i = 1'b0;
    chk("t4_err_cleared", 64'(bus.err_timeout_o), 64'd0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("renew_total", 64'(renew_total), 64'd11);
    chk("ack_total", 64'(ack_total), 64'd10);
    chk("ack_cnt0", 64'(ack_cnt[0]), 64'd2);
    chk("ack_cnt1", 64'(ack_cnt[1]), 64'd3);
    chk("ack_cnt2", 64'(ack_cnt[2]), 64'd3);
    chk("ack_cnt3", 64'(ack_cnt[3]), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
